// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared encodings for the ID/EX boundary: RegDst and MemtoReg selects, ALU
// operation codes, architectural register indices, the packed control word
// carried through ID/EX, and small helpers used by the stage.
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned SEL_W   = 2;

    // RegDst encodings (3 behaves like RD_RT)
    localparam logic [SEL_W-1:0] RD_RT = 2'd0;
    localparam logic [SEL_W-1:0] RD_RD = 2'd1;
    localparam logic [SEL_W-1:0] RD_RA = 2'd2;

    // MemtoReg encodings
    localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_PC4 = 2'd2;

    // ALUOp codes
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;

    // Architectural register indices
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] REG_RA   = 5'd31;

    // Control word carried from ID into EX
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 alu_src;
        logic [SEL_W-1:0]     mem_to_reg;
        logic [ALUOP_W-1:0]   alu_op;
    } ctrl_t;

    // Saturating increment for debug event counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Destination register select after RegDst decode
    function automatic logic [REG_W-1:0] dest_sel(
        input logic [SEL_W-1:0] reg_dst,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] ra
    );
        logic [REG_W-1:0] sel;
        sel = rt;
        case (reg_dst)
            RD_RD:   sel = rd;
            RD_RA:   sel = ra;
            default: sel = rt;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use detection for the instruction in ID against the
// load sitting in EX, and the resulting freeze request for PC and IF/ID.
// Ports:
//   id_valid, uses_rs, uses_rt, rs, rt : ID instruction and its source usage
//   ex_valid, ex_mem_read, ex_write_reg : registered EX-side state
//   flush, hold                         : pipeline control inputs
//   load_use_c                          : raw load-use hazard
//   stall_c                             : freeze PC and IF/ID this cycle
// ----------------------------------------------------------------------------
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             id_valid,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             flush,
    input  logic             hold,
    output logic             load_use_c,
    output logic             stall_c
);

    logic rs_hit;
    logic rt_hit;
    logic ex_load;

    // Only count a source match when the instruction really reads that field
    assign rs_hit  = uses_rs & (rs == ex_write_reg);
    assign rt_hit  = uses_rt & (rt == ex_write_reg);

    // A load targeting $0 produces nothing to wait for
    assign ex_load = ex_valid & ex_mem_read & (ex_write_reg != REG_ZERO);

    assign load_use_c = id_valid & ex_load & (rs_hit | rt_hit);

    // A taken branch/jump kills the ID instruction, so its hazard is moot
    assign stall_c = hold | (load_use_c & ~flush);

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS pipeline. Captures register-file
// read data, immediate, PC+4, source indices and the decoded control word,
// decodes the destination register, inserts bubbles on load-use stall or
// flush, freezes on downstream hold, and keeps saturating stall/flush counters.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   i_* (ID side)                  : instruction data, fields and control
//   i_Flush, i_Hold                : kill ID instruction / freeze stage
//   o_Stall                        : combinational freeze of PC and IF/ID
//   o_* (EX side)                  : registered copies for the EX stage
//   o_Stall_count, o_Flush_count   : saturating debug event counters
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned      DW     = 32,
    parameter logic [REG_W-1:0] RA_REG = REG_RA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_Valid,
    input  logic [DW-1:0]      i_Read_data1,
    input  logic [DW-1:0]      i_Read_data2,
    input  logic [REG_W-1:0]   i_Rs,
    input  logic [REG_W-1:0]   i_Rt,
    input  logic [REG_W-1:0]   i_Rd,
    input  logic               i_Uses_rs,
    input  logic               i_Uses_rt,
    input  logic [DW-1:0]      i_Imm_ext,
    input  logic [DW-1:0]      i_PC_plus4,
    input  logic               i_RegWrite,
    input  logic               i_MemRead,
    input  logic               i_MemWrite,
    input  logic               i_ALUSrc,
    input  logic [SEL_W-1:0]   i_MemtoReg,
    input  logic [SEL_W-1:0]   i_RegDst,
    input  logic [ALUOP_W-1:0] i_ALUOp,
    input  logic               i_Flush,
    input  logic               i_Hold,
    output logic               o_Stall,
    output logic               o_Valid,
    output logic [DW-1:0]      o_Read_data1,
    output logic [DW-1:0]      o_Read_data2,
    output logic [DW-1:0]      o_Imm_ext,
    output logic [DW-1:0]      o_PC_plus4,
    output logic [REG_W-1:0]   o_Rs,
    output logic [REG_W-1:0]   o_Rt,
    output logic [REG_W-1:0]   o_WriteReg,
    output logic               o_RegWrite,
    output logic               o_MemRead,
    output logic               o_MemWrite,
    output logic               o_ALUSrc,
    output logic [SEL_W-1:0]   o_MemtoReg,
    output logic [ALUOP_W-1:0] o_ALUOp,
    output logic [CNT_W-1:0]   o_Stall_count,
    output logic [CNT_W-1:0]   o_Flush_count
);

    // ID/EX register state
    logic             valid_q;
    logic [DW-1:0]    rd1_q;
    logic [DW-1:0]    rd2_q;
    logic [DW-1:0]    imm_q;
    logic [DW-1:0]    pc4_q;
    logic [REG_W-1:0] rs_q;
    logic [REG_W-1:0] rt_q;
    logic [REG_W-1:0] wr_q;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Next-capture values
    ctrl_t            ctrl_d;
    logic [REG_W-1:0] wr_d;
    logic             load_use;
    logic             stall;

    // Load-use detection against the instruction currently in EX
    hazard_detect u_hazard (
        .id_valid     (i_Valid),
        .uses_rs      (i_Uses_rs),
        .uses_rt      (i_Uses_rt),
        .rs           (i_Rs),
        .rt           (i_Rt),
        .ex_valid     (valid_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_write_reg (wr_q),
        .flush        (i_Flush),
        .hold         (i_Hold),
        .load_use_c   (load_use),
        .stall_c      (stall)
    );

    // Control word qualified by i_Valid so an invalid slot never has side effects
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.reg_write  = i_RegWrite & i_Valid;
        ctrl_d.mem_read   = i_MemRead  & i_Valid;
        ctrl_d.mem_write  = i_MemWrite & i_Valid;
        ctrl_d.alu_src    = i_ALUSrc   & i_Valid;
        ctrl_d.mem_to_reg = i_MemtoReg;
        ctrl_d.alu_op     = i_ALUOp;
        wr_d              = dest_sel(i_RegDst, i_Rt, i_Rd, RA_REG);
    end

    // Pipeline register and counters: reset > hold > flush > load-use > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wr_q      <= '0;
            ctrl_q    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (i_Hold) begin
            // downstream frozen: everything keeps its value
        end else if (i_Flush || load_use) begin
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wr_q    <= '0;
            ctrl_q  <= '0;
            if (i_Flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end else begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end else begin
            valid_q <= i_Valid;
            rd1_q   <= i_Read_data1;
            rd2_q   <= i_Read_data2;
            imm_q   <= i_Imm_ext;
            pc4_q   <= i_PC_plus4;
            rs_q    <= i_Rs;
            rt_q    <= i_Rt;
            wr_q    <= wr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign o_Stall       = stall;
    assign o_Valid       = valid_q;
    assign o_Read_data1  = rd1_q;
    assign o_Read_data2  = rd2_q;
    assign o_Imm_ext     = imm_q;
    assign o_PC_plus4    = pc4_q;
    assign o_Rs          = rs_q;
    assign o_Rt          = rt_q;
    assign o_WriteReg    = wr_q;
    assign o_RegWrite    = ctrl_q.reg_write;
    assign o_MemRead     = ctrl_q.mem_read;
    assign o_MemWrite    = ctrl_q.mem_write;
    assign o_ALUSrc      = ctrl_q.alu_src;
    assign o_MemtoReg    = ctrl_q.mem_to_reg;
    assign o_ALUOp       = ctrl_q.alu_op;
    assign o_Stall_count = stall_cnt;
    assign o_Flush_count = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage. Each cycle the expected EX
// state is computed from the applied inputs, queued, and compared against the
// DUT one clock later; key points also get directed constant checks.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_Valid;
    logic [31:0] i_Read_data1, i_Read_data2, i_Imm_ext, i_PC_plus4;
    logic [4:0]  i_Rs, i_Rt, i_Rd;
    logic        i_Uses_rs, i_Uses_rt;
    logic        i_RegWrite, i_MemRead, i_MemWrite, i_ALUSrc;
    logic [1:0]  i_MemtoReg, i_RegDst;
    logic [3:0]  i_ALUOp;
    logic        i_Flush, i_Hold;

    logic        o_Stall, o_Valid;
    logic [31:0] o_Read_data1, o_Read_data2, o_Imm_ext, o_PC_plus4;
    logic [4:0]  o_Rs, o_Rt, o_WriteReg;
    logic        o_RegWrite, o_MemRead, o_MemWrite, o_ALUSrc;
    logic [1:0]  o_MemtoReg;
    logic [3:0]  o_ALUOp;
    logic [31:0] o_Stall_count, o_Flush_count;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .i_Valid(i_Valid),
        .i_Read_data1(i_Read_data1), .i_Read_data2(i_Read_data2),
        .i_Rs(i_Rs), .i_Rt(i_Rt), .i_Rd(i_Rd),
        .i_Uses_rs(i_Uses_rs), .i_Uses_rt(i_Uses_rt),
        .i_Imm_ext(i_Imm_ext), .i_PC_plus4(i_PC_plus4),
        .i_RegWrite(i_RegWrite), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
        .i_ALUSrc(i_ALUSrc), .i_MemtoReg(i_MemtoReg), .i_RegDst(i_RegDst),
        .i_ALUOp(i_ALUOp), .i_Flush(i_Flush), .i_Hold(i_Hold),
        .o_Stall(o_Stall), .o_Valid(o_Valid),
        .o_Read_data1(o_Read_data1), .o_Read_data2(o_Read_data2),
        .o_Imm_ext(o_Imm_ext), .o_PC_plus4(o_PC_plus4),
        .o_Rs(o_Rs), .o_Rt(o_Rt), .o_WriteReg(o_WriteReg),
        .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_ALUSrc(o_ALUSrc), .o_MemtoReg(o_MemtoReg), .o_ALUOp(o_ALUOp),
        .o_Stall_count(o_Stall_count), .o_Flush_count(o_Flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, wr;
        logic        rw, mr, mw, as;
        logic [1:0]  m2r;
        logic [3:0]  op;
        logic [31:0] sc, fc;
    } exst_t;

    exst_t       model;
    exst_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    function automatic exst_t sample();
        exst_t s;
        s = '{o_Valid, o_Read_data1, o_Read_data2, o_Imm_ext, o_PC_plus4, o_Rs, o_Rt,
              o_WriteReg, o_RegWrite, o_MemRead, o_MemWrite, o_ALUSrc, o_MemtoReg,
              o_ALUOp, o_Stall_count, o_Flush_count};
        return s;
    endfunction

    function automatic logic [31:0] bump(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Expected EX state after the coming edge, from current inputs
    function automatic exst_t model_next(input exst_t m);
        exst_t n;
        logic  hit;
        hit = i_Valid && m.valid && m.mr && (m.wr != 5'd0) &&
              ((i_Uses_rs && i_Rs == m.wr) || (i_Uses_rt && i_Rt == m.wr));
        n = m;
        if (reset) begin
            n = '0;
        end else if (i_Hold) begin
            n = m;
        end else if (i_Flush || hit) begin
            n    = '0;
            n.sc = i_Flush ? m.sc : bump(m.sc);
            n.fc = i_Flush ? bump(m.fc) : m.fc;
        end else begin
            n.valid = i_Valid;
            n.rd1 = i_Read_data1;  n.rd2 = i_Read_data2;
            n.imm = i_Imm_ext;     n.pc4 = i_PC_plus4;
            n.rs  = i_Rs;          n.rt  = i_Rt;
            n.wr  = (i_RegDst == 2'd1) ? i_Rd : (i_RegDst == 2'd2) ? 5'd31 : i_Rt;
            n.rw  = i_RegWrite & i_Valid;  n.mr = i_MemRead & i_Valid;
            n.mw  = i_MemWrite & i_Valid;  n.as = i_ALUSrc & i_Valid;
            n.m2r = i_MemtoReg;    n.op = i_ALUOp;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check o_Stall before the edge, queue model, compare after it
    task automatic cycle(input string tag, input logic exp_stall);
        exst_t got;
        exst_t exp;
        @(negedge clk);
        chk({tag, "/stall"}, {31'd0, o_Stall}, {31'd0, exp_stall});
        model = model_next(model);
        sb.push_back(model);
        @(posedge clk);
        #1;
        got = sample();
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL %s/queue: observed empty expected entry", tag);
        end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
                n_bad++;
                $error("FAIL %s/regs: observed %h expected %h", tag, got, exp);
            end
        end
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, rt, rd,
                             input logic urs, urt, input logic [31:0] d1, d2, imm,
                             input logic rw, mr, mw, as,
                             input logic [1:0] m2r, rdst, input logic [3:0] op);
        i_Valid = v;  i_Rs = rs;  i_Rt = rt;  i_Rd = rd;
        i_Uses_rs = urs;  i_Uses_rt = urt;
        i_Read_data1 = d1;  i_Read_data2 = d2;  i_Imm_ext = imm;
        i_PC_plus4 = pc_ctr;  pc_ctr = pc_ctr + 32'd4;
        i_RegWrite = rw;  i_MemRead = mr;  i_MemWrite = mw;  i_ALUSrc = as;
        i_MemtoReg = m2r;  i_RegDst = rdst;  i_ALUOp = op;
    endtask

    task automatic lw(input logic [4:0] rt, rs);
        set_instr(1'b1, rs, rt, 5'd0, 1'b1, 1'b0, 32'h1000 + 32'(rs), 32'hDEAD, 32'd0,
                  1'b1, 1'b1, 1'b0, 1'b1, WB_MEM, RD_RT, ALU_ADD);
    endtask

    task automatic alu(input logic [4:0] rd, rs, rt, input logic urs, urt,
                       input logic [31:0] d1, d2);
        set_instr(1'b1, rs, rt, rd, urs, urt, d1, d2, 32'd0,
                  1'b1, 1'b0, 1'b0, 1'b0, WB_ALU, RD_RD, ALU_ADD);
    endtask

    initial begin
        model = '0;
        reset = 1'b1;  i_Flush = 1'b0;  i_Hold = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        cycle("reset", 1'b0);
        reset = 1'b0;
        chk("post_reset_stall", {31'd0, o_Stall}, 32'd0);
        chk("post_reset_scnt", o_Stall_count, 32'd0);

        // add $3,$1,$2
        alu(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5, 32'd7);
        cycle("add", 1'b0);
        chk("add_valid", {31'd0, o_Valid}, 32'd1);
        chk("add_wr", {27'd0, o_WriteReg}, 32'd3);
        chk("add_rd1", o_Read_data1, 32'd5);
        chk("add_rd2", o_Read_data2, 32'd7);
        chk("add_rw", {31'd0, o_RegWrite}, 32'd1);

        // lw $8,0($9) then add $10,$8,$1
        lw(5'd8, 5'd9);
        cycle("lw8", 1'b0);
        alu(5'd10, 5'd8, 5'd1, 1'b1, 1'b1, 32'h11, 32'h22);
        cycle("lu_stall", 1'b1);
        chk("lu_bubble_valid", {31'd0, o_Valid}, 32'd0);
        chk("lu_bubble_mr", {31'd0, o_MemRead}, 32'd0);
        chk("lu_scnt", o_Stall_count, 32'd1);
        cycle("lu_retry", 1'b0);
        chk("lu_retry_wr", {27'd0, o_WriteReg}, 32'd10);

        // lw $0 followed by a user of $0
        lw(5'd0, 5'd9);
        cycle("lw0", 1'b0);
        alu(5'd4, 5'd0, 5'd2, 1'b1, 1'b1, 32'd0, 32'd9);
        cycle("use0", 1'b0);

        // lw $8 followed by a non-reader of rt=8
        lw(5'd8, 5'd9);
        cycle("lw8b", 1'b0);
        alu(5'd6, 5'd5, 5'd8, 1'b1, 1'b0, 32'd1, 32'd2);
        cycle("no_rt_use", 1'b0);

        // back-to-back dependent loads
        lw(5'd8, 5'd9);
        cycle("b2b_lw8", 1'b0);
        lw(5'd9, 5'd8);
        cycle("b2b_lw9_stall", 1'b1);
        cycle("b2b_lw9_go", 1'b0);
        alu(5'd7, 5'd9, 5'd3, 1'b1, 1'b1, 32'd3, 32'd4);
        cycle("b2b_add_stall", 1'b1);
        cycle("b2b_add_go", 1'b0);
        chk("b2b_scnt", o_Stall_count, 32'd3);

        // flush beats stall
        lw(5'd8, 5'd9);
        cycle("fl_lw8", 1'b0);
        alu(5'd10, 5'd8, 5'd1, 1'b1, 1'b1, 32'd1, 32'd1);
        i_Flush = 1'b1;
        cycle("flush", 1'b0);
        i_Flush = 1'b0;
        chk("flush_fcnt", o_Flush_count, 32'd1);
        chk("flush_scnt", o_Stall_count, 32'd3);
        chk("flush_valid", {31'd0, o_Valid}, 32'd0);

        // hold for 3 cycles with changing inputs
        alu(5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 32'hAA, 32'hBB);
        cycle("pre_hold", 1'b0);
        i_Hold = 1'b1;
        alu(5'd12, 5'd3, 5'd4, 1'b1, 1'b1, 32'h1, 32'h2);
        cycle("hold1", 1'b1);
        i_Flush = 1'b1;
        alu(5'd13, 5'd5, 5'd6, 1'b1, 1'b1, 32'h3, 32'h4);
        cycle("hold2", 1'b1);
        i_Flush = 1'b0;
        lw(5'd14, 5'd7);
        cycle("hold3", 1'b1);
        chk("hold_rd1", o_Read_data1, 32'hAA);
        chk("hold_fcnt", o_Flush_count, 32'd1);
        i_Hold = 1'b0;
        set_instr(1'b1, 5'd2, 5'd12, 5'd13, 1'b1, 1'b0, 32'h55, 32'h66, 32'h8,
                  1'b1, 1'b0, 1'b0, 1'b1, WB_ALU, 2'd3, ALU_OR);
        cycle("release", 1'b0);
        chk("release_wr_rd3", {27'd0, o_WriteReg}, 32'd12);
        chk("release_rd1", o_Read_data1, 32'h55);

        // jal link destination
        set_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h100,
                  1'b1, 1'b0, 1'b0, 1'b0, WB_PC4, RD_RA, ALU_ADD);
        cycle("jal", 1'b0);
        chk("jal_wr", {27'd0, o_WriteReg}, 32'd31);

        // invalid slot never writes
        set_instr(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0,
                  1'b1, 1'b1, 1'b1, 1'b0, WB_MEM, RD_RD, ALU_ADD);
        cycle("invalid", 1'b0);
        chk("invalid_rw", {29'd0, o_RegWrite, o_MemRead, o_MemWrite}, 32'd0);

        // stall counter saturation
        lw(5'd8, 5'd9);
        cycle("sat_lw", 1'b0);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        model.sc = 32'hFFFF_FFFE;
        chk("sat_preload", o_Stall_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                lw(5'd8, 5'd9);
                cycle("sat_lw", 1'b0);
            end
            alu(5'd10, 5'd8, 5'd1, 1'b1, 1'b1, 32'd1, 32'd2);
            cycle("sat_stall", 1'b1);
            chk("sat_scnt", o_Stall_count, 32'hFFFF_FFFF);
            cycle("sat_go", 1'b0);
        end

        // reset clears counters again
        reset = 1'b1;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        cycle("reset2", 1'b0);
        reset = 1'b0;
        chk("reset2_scnt", o_Stall_count, 32'd0);
        chk("reset2_fcnt", o_Flush_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
